bit_serializer: RTL and testbench

Parallel-in, serial-out stage that sits directly upstream of the consecutive-ones sequence detector. It accepts a WIDTH-bit word through a valid/ready handshake and shifts it out one bit per clock on a serial line that drives the detector's `x` input. A qualifying valid strobe and an end-of-frame pulse accompany the stream. Back-to-back words stream without a gap bit.

---
 rtl/bit_serializer_pkg.sv | 18 +
 rtl/bit_serializer_counter.sv | 29 ++
 rtl/bit_serializer.sv | 125 ++++++++++++
 tb/tb_bit_serializer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/bit_serializer_pkg.sv
// Shared definitions for the bit_serializer slice: FSM state encoding,
// default word width and the bit-counter width helper.
package serializer_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SHIFT  = 2'b01,
    ST_PARITY = 2'b10
  } ser_state_t;

  // Width of a counter that must reach width-1; never narrower than one bit.
  function automatic int unsigned count_width(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/bit_serializer_counter.sv
// bit_counter: up-counter with synchronous clear, enable and a terminal-count
// flag. It holds at TERMINAL instead of wrapping.
module bit_counter #(
  parameter int unsigned CW       = 3,
  parameter int unsigned TERMINAL = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          tc
);

  localparam logic [CW-1:0] TC_VAL = CW'(TERMINAL);

  // Count register: clear wins over enable, saturates at the terminal value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (en && !tc)
      count <= count + 1'b1;
  end

  assign tc = (count == TC_VAL);

endmodule

// File: rtl/bit_serializer.sv
// bit_serializer: parallel-in, serial-out stage feeding the consecutive-ones
// detector. Accepts a WIDTH-bit word on a valid/ready handshake and shifts it
// out one bit per clock, streaming back-to-back words without a gap bit.
// Optional feature macro: BIT_SERIALIZER_PARITY_EN appends an even-parity bit
// after each word and moves frame_done to that parity cycle.
module bit_serializer
  import serializer_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter bit          LSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             frame_done
);

  localparam int unsigned CW = count_width(WIDTH);

  ser_state_t       state;
  ser_state_t       state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    bit_cnt;
  logic             last_bit;
  logic             accept;
  logic             cnt_clr;
  logic             cnt_en;

`ifdef BIT_SERIALIZER_PARITY_EN
  logic             par_bit;
`endif

  // load_ready is decoded from registered state only, so accept carries no
  // path from load_valid back to any output.
  assign accept  = load_valid && load_ready;
  assign cnt_en  = (state == ST_SHIFT);
  assign cnt_clr = accept || ((state == ST_SHIFT) && last_bit);

  bit_counter #(
    .CW       (CW),
    .TERMINAL (WIDTH - 1)
  ) u_bit_counter (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .count (bit_cnt),
    .tc    (last_bit)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  // Shift register: capture on handshake, otherwise shift while in SHIFT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      shreg <= '0;
    else if (accept)
      shreg <= load_data;
    else if (state == ST_SHIFT)
      shreg <= LSB_FIRST ? (shreg >> 1) : (shreg << 1);
  end

`ifdef BIT_SERIALIZER_PARITY_EN
  // Even-parity bit of the captured word, sent after the last data bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      par_bit <= 1'b0;
    else if (accept)
      par_bit <= ^load_data;
  end
`endif

  // Next-state and output decode. Where load_ready is 1, load_valid alone
  // decides acceptance, keeping this block free of a self-referencing loop.
  always_comb begin
    state_nxt    = state;
    load_ready   = 1'b0;
    serial_out   = 1'b0;
    serial_valid = 1'b0;
    frame_done   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        load_ready = 1'b1;
        if (load_valid)
          state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        serial_valid = 1'b1;
        serial_out   = LSB_FIRST ? shreg[0] : shreg[WIDTH-1];
        if (last_bit) begin
`ifdef BIT_SERIALIZER_PARITY_EN
          state_nxt = ST_PARITY;
`else
          frame_done = 1'b1;
          load_ready = 1'b1;
          state_nxt  = load_valid ? ST_SHIFT : ST_IDLE;
`endif
        end
      end
`ifdef BIT_SERIALIZER_PARITY_EN
      ST_PARITY: begin
        serial_valid = 1'b1;
        serial_out   = par_bit;
        frame_done   = 1'b1;
        load_ready   = 1'b1;
        state_nxt    = load_valid ? ST_SHIFT : ST_IDLE;
      end
`endif
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Directed self-checking bench for bit_serializer. Two instances share the
// stimulus: one MSB-first, one LSB-first. Honours BIT_SERIALIZER_PARITY_EN.
module tb_bit_serializer;

  localparam int W = 8;
`ifdef BIT_SERIALIZER_PARITY_EN
  localparam int F = W + 1;
`else
  localparam int F = W;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load_valid = 1'b0;
  logic [7:0] load_data = 8'h00;

  logic m_ready, m_out, m_valid, m_done;
  logic l_ready, l_out, l_valid, l_done;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_m (
    .clk          (clk),
    .rst          (rst),
    .load_valid   (load_valid),
    .load_data    (load_data),
    .load_ready   (m_ready),
    .serial_out   (m_out),
    .serial_valid (m_valid),
    .frame_done   (m_done)
  );

  bit_serializer #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_l (
    .clk          (clk),
    .rst          (rst),
    .load_valid   (load_valid),
    .load_data    (load_data),
    .load_ready   (l_ready),
    .serial_out   (l_out),
    .serial_valid (l_valid),
    .frame_done   (l_done)
  );

  // Outputs are compared as {load_ready, serial_out, serial_valid, frame_done}.

  task automatic test_reset();
    rst = 1'b1;
    load_valid = 1'b0;
    load_data = 8'h00;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({m_ready, m_out, m_valid, m_done, l_ready, l_out, l_valid, l_done} !== 8'b1000_1000) begin
      tests_failed++;
      $display("FAIL reset_values got %b exp %b",
               {m_ready, m_out, m_valid, m_done, l_ready, l_out, l_valid, l_done}, 8'b1000_1000);
    end
    rst = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      tests_run++;
      if ({m_ready, m_out, m_valid, m_done} !== 4'b1000) begin
        tests_failed++;
        $display("FAIL idle_cycle%0d got %b exp %b", c, {m_ready, m_out, m_valid, m_done}, 4'b1000);
      end
    end
  endtask

  task automatic test_msb_first(input logic [7:0] w);
    logic eb;
    logic last;
    load_valid = 1'b1;
    load_data = w;
    @(negedge clk);
    load_valid = 1'b0;
    for (int i = 0; i < F; i++) begin
      eb = (i < W) ? w[W-1-i] : ^w;
      last = (i == F - 1);
      tests_run++;
      if ({m_ready, m_out, m_valid, m_done} !== {last, eb, 1'b1, last}) begin
        tests_failed++;
        $display("FAIL msb_%h_cycle%0d got %b exp %b", w, i + 1,
                 {m_ready, m_out, m_valid, m_done}, {last, eb, 1'b1, last});
      end
      @(negedge clk);
    end
    tests_run++;
    if ({m_ready, m_out, m_valid, m_done} !== 4'b1000) begin
      tests_failed++;
      $display("FAIL msb_%h_return_idle got %b exp %b", w, {m_ready, m_out, m_valid, m_done}, 4'b1000);
    end
  endtask

  task automatic test_lsb_first(input logic [7:0] w);
    logic eb;
    logic last;
    load_valid = 1'b1;
    load_data = w;
    @(negedge clk);
    load_valid = 1'b0;
    for (int i = 0; i < F; i++) begin
      eb = (i < W) ? w[i] : ^w;
      last = (i == F - 1);
      tests_run++;
      if ({l_ready, l_out, l_valid, l_done} !== {last, eb, 1'b1, last}) begin
        tests_failed++;
        $display("FAIL lsb_%h_cycle%0d got %b exp %b", w, i + 1,
                 {l_ready, l_out, l_valid, l_done}, {last, eb, 1'b1, last});
      end
      @(negedge clk);
    end
    tests_run++;
    if ({l_ready, l_out, l_valid, l_done} !== 4'b1000) begin
      tests_failed++;
      $display("FAIL lsb_%h_return_idle got %b exp %b", w, {l_ready, l_out, l_valid, l_done}, 4'b1000);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] w;
    logic eb;
    logic last;
    int i;
    load_valid = 1'b1;
    load_data = 8'hFF;
    @(negedge clk);
    load_data = 8'h01;  // ignored until load_ready rises on the last cycle
    for (int c = 1; c <= 2 * F; c++) begin
      w = (c <= F) ? 8'hFF : 8'h01;
      i = (c - 1) % F;
      eb = (i < W) ? w[W-1-i] : ^w;
      last = (i == F - 1);
      tests_run++;
      if ({m_ready, m_out, m_valid, m_done} !== {last, eb, 1'b1, last}) begin
        tests_failed++;
        $display("FAIL b2b_cycle%0d got %b exp %b", c,
                 {m_ready, m_out, m_valid, m_done}, {last, eb, 1'b1, last});
      end
      if (c == F + 1)
        load_valid = 1'b0;
      @(negedge clk);
    end
    tests_run++;
    if ({m_ready, m_out, m_valid, m_done} !== 4'b1000) begin
      tests_failed++;
      $display("FAIL b2b_return_idle got %b exp %b", {m_ready, m_out, m_valid, m_done}, 4'b1000);
    end
  endtask

  task automatic test_reset_mid_frame();
    load_valid = 1'b1;
    load_data = 8'hFF;
    @(negedge clk);
    load_valid = 1'b0;
    // Bits 0..3 go out, then reset lands while bit 4 is on the line.
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if ({m_ready, m_out, m_valid, m_done} !== 4'b0110) begin
        tests_failed++;
        $display("FAIL midrst_bit%0d got %b exp %b", i, {m_ready, m_out, m_valid, m_done}, 4'b0110);
      end
      @(negedge clk);
    end
    #1 rst = 1'b1;
    #1;
    tests_run++;
    if ({m_ready, m_out, m_valid, m_done, l_ready, l_out, l_valid, l_done} !== 8'b1000_1000) begin
      tests_failed++;
      $display("FAIL midrst_async got %b exp %b",
               {m_ready, m_out, m_valid, m_done, l_ready, l_out, l_valid, l_done}, 8'b1000_1000);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      tests_run++;
      if ({m_ready, m_out, m_valid, m_done} !== 4'b1000) begin
        tests_failed++;
        $display("FAIL midrst_after%0d got %b exp %b", c, {m_ready, m_out, m_valid, m_done}, 4'b1000);
      end
    end
  endtask

`ifdef BIT_SERIALIZER_PARITY_EN
  task automatic test_parity();
    logic [7:0] words [2];
    logic exp_par [2];
    words[0] = 8'hB4; exp_par[0] = 1'b0;
    words[1] = 8'h07; exp_par[1] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      load_valid = 1'b1;
      load_data = words[k];
      @(negedge clk);
      load_valid = 1'b0;
      repeat (W) @(negedge clk);
      tests_run++;
      if ({m_ready, m_out, m_valid, m_done} !== {1'b1, exp_par[k], 1'b1, 1'b1}) begin
        tests_failed++;
        $display("FAIL parity_%h got %b exp %b", words[k],
                 {m_ready, m_out, m_valid, m_done}, {1'b1, exp_par[k], 1'b1, 1'b1});
      end
      @(negedge clk);
      tests_run++;
      if ({m_ready, m_out, m_valid, m_done} !== 4'b1000) begin
        tests_failed++;
        $display("FAIL parity_%h_idle got %b exp %b", words[k], {m_ready, m_out, m_valid, m_done}, 4'b1000);
      end
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_msb_first(8'hB4);
    test_back_to_back();
    test_lsb_first(8'hB4);
    test_reset_mid_frame();
    test_msb_first(8'hB4);
`ifdef BIT_SERIALIZER_PARITY_EN
    test_parity();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
